// File: rtl/ccie_wr_arbiter.sv
// Shares the CCI write-request channel between requesters A and B: per-requester 4-deep FIFOs,
// round-robin issue gated by CCI backpressure and outstanding limits, and response routing by mdata tag.

module ccie_wr_arbiter_req #(
  parameter int  MAX_OUTST = 32,
  parameter type req_t     = logic
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_i,
  input  req_t       push_req_i,
  input  logic       pop_i,
  input  logic [1:0] rsp_hit_i,
  output req_t       head_o,
  output logic       elig_o,
  output logic       almostfull_o,
  output logic       quiet_d_o,
  output logic       err_o
);
  localparam logic [5:0] MAXO = 6'(MAX_OUTST);

  req_t       mem_q [4];
  logic [1:0] wptr_q, rptr_q;
  logic [2:0] cnt_q, cnt_d;
  logic [5:0] outst_q, outst_d;
  logic [6:0] inc;
  logic [1:0] dec;
  logic       full, do_push, unf, af_q;

  // A push into a full FIFO is dropped even if the head pops this cycle.
  always_comb begin
    full    = cnt_q == 3'd4;
    do_push = push_i && !full;
    cnt_d   = cnt_q + 3'(do_push) - 3'(pop_i);
    inc     = {1'b0, outst_q} + 7'(pop_i);
    dec     = 2'(rsp_hit_i[0]) + 2'(rsp_hit_i[1]);
    unf     = inc < 7'(dec);
    outst_d = unf ? '0 : 6'(inc - 7'(dec));
    err_o   = (push_i && full) || unf;
  end

  assign head_o       = mem_q[rptr_q];
  assign elig_o       = (cnt_q != 3'd0) && (outst_q < MAXO);
  assign almostfull_o = af_q;
  assign quiet_d_o    = (cnt_d == 3'd0) && (outst_d == 6'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      outst_q <= '0;
      af_q    <= 1'b0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 2'd1;
      if (pop_i)   rptr_q <= rptr_q + 2'd1;
      cnt_q   <= cnt_d;
      outst_q <= outst_d;
      af_q    <= cnt_d >= 3'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_req_i;
  end
endmodule

module ccie_wr_arbiter #(
  parameter int ADDR_LMT    = 20,
  parameter int MDATA       = 14,
  parameter int CACHE_WIDTH = 512,
  parameter int MAX_OUTST   = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [ADDR_LMT-1:0]    a_wr_addr,
  input  logic [MDATA-2:0]       a_wr_mdata,
  input  logic [CACHE_WIDTH-1:0] a_wr_data,
  input  logic                   a_wr_en,
  output logic                   a_wr_almostfull,
  input  logic [ADDR_LMT-1:0]    b_wr_addr,
  input  logic [MDATA-2:0]       b_wr_mdata,
  input  logic [CACHE_WIDTH-1:0] b_wr_data,
  input  logic                   b_wr_en,
  output logic                   b_wr_almostfull,
  output logic [1:0]             a_rsp_valid,
  output logic [MDATA-2:0]       a_rsp_mdata0,
  output logic [MDATA-2:0]       a_rsp_mdata1,
  output logic [1:0]             b_rsp_valid,
  output logic [MDATA-2:0]       b_rsp_mdata0,
  output logic [MDATA-2:0]       b_rsp_mdata1,
  output logic [ADDR_LMT-1:0]    wr_req_addr,
  output logic [MDATA-1:0]       wr_req_mdata,
  output logic [CACHE_WIDTH-1:0] wr_req_data,
  output logic                   wr_req_en,
  input  logic                   wr_req_almostfull,
  input  logic                   wr_rsp0_valid,
  input  logic [MDATA-1:0]       wr_rsp0_mdata,
  input  logic                   wr_rsp1_valid,
  input  logic [MDATA-1:0]       wr_rsp1_mdata,
  output logic                   idle,
  output logic                   err
);
  typedef struct packed {
    logic [ADDR_LMT-1:0]    addr;
    logic [MDATA-2:0]       mdata;
    logic [CACHE_WIDTH-1:0] data;
  } req_t;

  req_t [1:0]       push_req, head;
  logic [1:0]       push, pop, elig, af, quiet, err_p;
  logic [1:0][1:0]  hit;
  logic             gsel, rr_q, rr_d;

  logic [ADDR_LMT-1:0]    addr_q;
  logic [MDATA-1:0]       mdata_q;
  logic [CACHE_WIDTH-1:0] data_q;
  logic                   en_q, idle_q, err_q;

  assign push_req[0] = {a_wr_addr, a_wr_mdata, a_wr_data};
  assign push_req[1] = {b_wr_addr, b_wr_mdata, b_wr_data};
  assign push        = {b_wr_en, a_wr_en};

  // hit[x][p]: CCI response port p belongs to requester x (tag 0 = A, 1 = B)
  assign hit[0] = {wr_rsp1_valid & ~wr_rsp1_mdata[MDATA-1], wr_rsp0_valid & ~wr_rsp0_mdata[MDATA-1]};
  assign hit[1] = {wr_rsp1_valid &  wr_rsp1_mdata[MDATA-1], wr_rsp0_valid &  wr_rsp0_mdata[MDATA-1]};

  for (genvar x = 0; x < 2; x++) begin : g_req
    ccie_wr_arbiter_req #(
      .MAX_OUTST (MAX_OUTST),
      .req_t     (req_t)
    ) u_req (
      .clk          (clk),
      .reset_n      (reset_n),
      .push_i       (push[x]),
      .push_req_i   (push_req[x]),
      .pop_i        (pop[x]),
      .rsp_hit_i    (hit[x]),
      .head_o       (head[x]),
      .elig_o       (elig[x]),
      .almostfull_o (af[x]),
      .quiet_d_o    (quiet[x]),
      .err_o        (err_p[x])
    );
  end

  // The pointer only advances on a contested grant, so a lone requester never loses its turn.
  always_comb begin
    pop  = '0;
    rr_d = rr_q;
    if (!wr_req_almostfull) begin
      if (&elig) begin
        pop[rr_q] = 1'b1;
        rr_d      = ~rr_q;
      end else begin
        pop = elig;
      end
    end
  end

  assign gsel = pop[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q    <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      mdata_q <= '0;
      data_q  <= '0;
      idle_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      en_q   <= |pop;
      idle_q <= (&quiet) && !(|pop);
      err_q  <= err_q || (|err_p);
      if (|pop) begin
        addr_q  <= head[gsel].addr;
        mdata_q <= {gsel, head[gsel].mdata};
        data_q  <= head[gsel].data;
      end
    end
  end

  assign wr_req_en       = en_q;
  assign wr_req_addr     = addr_q;
  assign wr_req_mdata    = mdata_q;
  assign wr_req_data     = data_q;
  assign a_wr_almostfull = af[0];
  assign b_wr_almostfull = af[1];
  assign a_rsp_valid     = hit[0];
  assign b_rsp_valid     = hit[1];
  assign a_rsp_mdata0    = wr_rsp0_mdata[MDATA-2:0];
  assign a_rsp_mdata1    = wr_rsp1_mdata[MDATA-2:0];
  assign b_rsp_mdata0    = wr_rsp0_mdata[MDATA-2:0];
  assign b_rsp_mdata1    = wr_rsp1_mdata[MDATA-2:0];
  assign idle            = idle_q;
  assign err             = err_q;
endmodule

// File: tb/tb_ccie_wr_arbiter.sv
// Randomized bench for ccie_wr_arbiter: a queue-based reference model predicts each CCI issue
// into a scoreboard; a negedge monitor pops and compares, and checks flags and response routing.
module tb_ccie_wr_arbiter;
  localparam int AL = 20, MD = 14, CW = 512, MO = 3, MDW = MD - 1;

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [AL-1:0] a_wr_addr, b_wr_addr, wr_req_addr;
  logic [MDW-1:0] a_wr_mdata, b_wr_mdata, a_rsp_mdata0, a_rsp_mdata1, b_rsp_mdata0, b_rsp_mdata1;
  logic [CW-1:0] a_wr_data, b_wr_data, wr_req_data;
  logic a_wr_en, b_wr_en, a_wr_almostfull, b_wr_almostfull, wr_req_en, wr_req_almostfull;
  logic [1:0] a_rsp_valid, b_rsp_valid;
  logic [MD-1:0] wr_req_mdata, wr_rsp0_mdata, wr_rsp1_mdata;
  logic wr_rsp0_valid, wr_rsp1_valid, idle, err;

  ccie_wr_arbiter #(.ADDR_LMT(AL), .MDATA(MD), .CACHE_WIDTH(CW), .MAX_OUTST(MO)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_wr_addr(a_wr_addr), .a_wr_mdata(a_wr_mdata), .a_wr_data(a_wr_data), .a_wr_en(a_wr_en),
    .a_wr_almostfull(a_wr_almostfull),
    .b_wr_addr(b_wr_addr), .b_wr_mdata(b_wr_mdata), .b_wr_data(b_wr_data), .b_wr_en(b_wr_en),
    .b_wr_almostfull(b_wr_almostfull),
    .a_rsp_valid(a_rsp_valid), .a_rsp_mdata0(a_rsp_mdata0), .a_rsp_mdata1(a_rsp_mdata1),
    .b_rsp_valid(b_rsp_valid), .b_rsp_mdata0(b_rsp_mdata0), .b_rsp_mdata1(b_rsp_mdata1),
    .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
    .wr_req_en(wr_req_en), .wr_req_almostfull(wr_req_almostfull),
    .wr_rsp0_valid(wr_rsp0_valid), .wr_rsp0_mdata(wr_rsp0_mdata),
    .wr_rsp1_valid(wr_rsp1_valid), .wr_rsp1_mdata(wr_rsp1_mdata),
    .idle(idle), .err(err)
  );

  typedef struct {logic [AL-1:0] addr; logic [MDW-1:0] md; logic [CW-1:0] data;} ent_t;
  typedef struct {logic [AL-1:0] addr; logic [MD-1:0] md; logic [CW-1:0] data;} txn_t;

  // Reference model state: FIFO contents, in-flight counts, RR turn, sticky error.
  ent_t mq[2][$];
  logic [MDW-1:0] infl[2][$];
  txn_t expq[$];
  int mout[2];
  int mrr;
  bit merr, men, mrst;

  int nchk = 0, nerr = 0;
  int push_pct, rsp_pct, bp_mode;
  bit polite, mon_on;

  task automatic chk(string nm, logic [CW-1:0] act, logic [CW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] rnd_data();
    logic [CW-1:0] d;
    d = '0;
    for (int i = 0; i < CW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic model_clear();
    for (int x = 0; x < 2; x++) begin
      mq[x].delete();
      infl[x].delete();
      mout[x] = 0;
    end
    expq.delete();
    mrr = 0; merr = 0; men = 0; mrst = 1;
  endtask

  // One clock of the reference model, evaluated on the inputs held across the edge.
  task automatic model_step();
    bit full[2], elig[2], pv[2];
    ent_t pe[2];
    int g, n, hits;
    txn_t t;
    ent_t e;
    for (int x = 0; x < 2; x++) begin
      full[x] = mq[x].size() == 4;
      elig[x] = mq[x].size() > 0 && mout[x] < MO;
    end
    g = -1;
    if (!wr_req_almostfull) begin
      if (elig[0] && elig[1]) begin g = mrr; mrr = 1 - mrr; end
      else if (elig[0]) g = 0;
      else if (elig[1]) g = 1;
    end
    men = g >= 0;
    if (g >= 0) begin
      e = mq[g].pop_front();
      t.addr = e.addr; t.md = {g[0], e.md}; t.data = e.data;
      expq.push_back(t);
      infl[g].push_back(e.md);
    end
    pv[0] = a_wr_en; pe[0].addr = a_wr_addr; pe[0].md = a_wr_mdata; pe[0].data = a_wr_data;
    pv[1] = b_wr_en; pe[1].addr = b_wr_addr; pe[1].md = b_wr_mdata; pe[1].data = b_wr_data;
    for (int x = 0; x < 2; x++) begin
      if (pv[x]) begin
        if (full[x]) merr = 1;
        else mq[x].push_back(pe[x]);
      end
      hits = 0;
      if (wr_rsp0_valid && wr_rsp0_mdata[MD-1] == x[0]) hits++;
      if (wr_rsp1_valid && wr_rsp1_mdata[MD-1] == x[0]) hits++;
      n = mout[x] + ((g == x) ? 1 : 0) - hits;
      if (n < 0) begin n = 0; merr = 1; end
      mout[x] = n;
    end
    mrst = 0;
  endtask

  task automatic clear_inputs();
    a_wr_en = 0; b_wr_en = 0; a_wr_addr = '0; b_wr_addr = '0; a_wr_mdata = '0; b_wr_mdata = '0;
    a_wr_data = '0; b_wr_data = '0; wr_req_almostfull = 0;
    wr_rsp0_valid = 0; wr_rsp0_mdata = '0; wr_rsp1_valid = 0; wr_rsp1_mdata = '0;
  endtask

  task automatic drive();
    bit v;
    int x;
    logic [MD-1:0] m;
    a_wr_en = 0; b_wr_en = 0;
    if ($urandom_range(99) < push_pct && !(polite && mq[0].size() >= 2)) begin
      a_wr_en = 1; a_wr_addr = AL'($urandom); a_wr_mdata = MDW'($urandom); a_wr_data = rnd_data();
    end
    if ($urandom_range(99) < push_pct && !(polite && mq[1].size() >= 2)) begin
      b_wr_en = 1; b_wr_addr = AL'($urandom); b_wr_mdata = MDW'($urandom); b_wr_data = rnd_data();
    end
    case (bp_mode)
      0: wr_req_almostfull = $urandom_range(99) < 25;
      1: wr_req_almostfull = 1;
      default: wr_req_almostfull = 0;
    endcase
    for (int p = 0; p < 2; p++) begin
      v = 0; m = '0;
      if ($urandom_range(99) < rsp_pct) begin
        x = $urandom_range(1);
        if (infl[x].size() == 0) x = 1 - x;
        if (infl[x].size() > 0) begin v = 1; m = {x[0], infl[x].pop_front()}; end
      end
      if (p == 0) begin wr_rsp0_valid = v; wr_rsp0_mdata = m; end
      else begin wr_rsp1_valid = v; wr_rsp1_mdata = m; end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_step();
    #1 drive();
  endtask

  task automatic run(int n, int pp, int rp, int bp, bit pol);
    push_pct = pp; rsp_pct = rp; bp_mode = bp; polite = pol;
    repeat (n) cycle();
  endtask

  // Monitor: scoreboard pop on every issue, plus per-cycle flag and routing checks.
  always @(negedge clk) begin : mon
    txn_t t;
    logic [1:0] eav, ebv;
    if (mon_on) begin
      if (wr_req_en) begin
        if (expq.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_issue: got mdata %0h with no expected issue pending", wr_req_mdata);
        end else begin
          t = expq.pop_front();
          chk("req_addr", CW'(wr_req_addr), CW'(t.addr));
          chk("req_mdata", CW'(wr_req_mdata), CW'(t.md));
          chk("req_data", wr_req_data, t.data);
        end
      end
      chk("req_en", CW'(wr_req_en), CW'(men));
      chk("a_almostfull", CW'(a_wr_almostfull), CW'(!mrst && mq[0].size() >= 2));
      chk("b_almostfull", CW'(b_wr_almostfull), CW'(!mrst && mq[1].size() >= 2));
      chk("err", CW'(err), CW'(merr));
      chk("idle", CW'(idle), CW'(!mrst && mq[0].size() == 0 && mq[1].size() == 0 && !men &&
                                 mout[0] == 0 && mout[1] == 0));
      eav = {wr_rsp1_valid && !wr_rsp1_mdata[MD-1], wr_rsp0_valid && !wr_rsp0_mdata[MD-1]};
      ebv = {wr_rsp1_valid &&  wr_rsp1_mdata[MD-1], wr_rsp0_valid &&  wr_rsp0_mdata[MD-1]};
      chk("a_rsp_valid", CW'(a_rsp_valid), CW'(eav));
      chk("b_rsp_valid", CW'(b_rsp_valid), CW'(ebv));
      if (eav[0]) chk("a_rsp_mdata0", CW'(a_rsp_mdata0), CW'(wr_rsp0_mdata[MDW-1:0]));
      if (eav[1]) chk("a_rsp_mdata1", CW'(a_rsp_mdata1), CW'(wr_rsp1_mdata[MDW-1:0]));
      if (ebv[0]) chk("b_rsp_mdata0", CW'(b_rsp_mdata0), CW'(wr_rsp0_mdata[MDW-1:0]));
      if (ebv[1]) chk("b_rsp_mdata1", CW'(b_rsp_mdata1), CW'(wr_rsp1_mdata[MDW-1:0]));
      if (mrst) begin
        chk("rst_addr", CW'(wr_req_addr), '0);
        chk("rst_mdata", CW'(wr_req_mdata), '0);
        chk("rst_data", wr_req_data, '0);
      end
    end
  end

  initial begin
    clear_inputs();
    model_clear();
    mon_on = 1;
    push_pct = 0; rsp_pct = 0; bp_mode = 2; polite = 1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    run(3, 0, 0, 2, 1);

    // A alone pushes three lines back to back
    push_pct = 0; rsp_pct = 0; bp_mode = 2; polite = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); model_step();
      #1 drive();
      a_wr_en = 1; a_wr_addr = AL'(i + 16); a_wr_mdata = MDW'(i + 1); a_wr_data = rnd_data();
    end
    run(8, 0, 50, 2, 0);
    run(12, 0, 100, 2, 0);

    // A and B push four lines in the same cycles
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); model_step();
      #1 drive();
      a_wr_en = 1; a_wr_addr = AL'(i + 32); a_wr_mdata = MDW'(i + 8); a_wr_data = rnd_data();
      b_wr_en = 1; b_wr_addr = AL'(i + 48); b_wr_mdata = MDW'(i + 12); b_wr_data = rnd_data();
    end
    run(20, 0, 60, 2, 0);

    // Well-behaved random traffic honouring almostfull
    run(1500, 60, 40, 0, 1);
    run(300, 90, 20, 0, 1);

    // Backpressure with pushes past full: overflow sets the sticky error
    run(10, 100, 0, 1, 0);
    run(400, 70, 40, 0, 0);

    // Reset in the middle of a burst
    @(posedge clk); model_step();
    #1 reset_n = 0; clear_inputs(); model_clear();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    run(2, 0, 0, 2, 1);

    // Stray response tagged B with nothing outstanding: underflow
    @(posedge clk); model_step();
    #1 drive();
    wr_rsp0_valid = 1; wr_rsp0_mdata = {1'b1, MDW'(13'h0005)};
    run(4, 0, 0, 2, 1);
    run(400, 60, 40, 0, 1);

    // Drain everything and confirm the block returns to idle
    run(60, 0, 100, 2, 1);
    @(negedge clk);
    chk("drain_scoreboard_empty", CW'(expq.size()), '0);
    chk("drain_idle", CW'(idle), CW'(1));

    mon_on = 0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
